// File: rtl/dmem_access_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: port A (MEM stage) has
// priority, port B (debug/loader) is protected from starvation by a bounded wait counter.
module dmem_access_arbiter #(
  parameter int LATENCY      = 2,
  parameter int ADDR_LIMIT   = 208,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        stall,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  // state  | meaning
  // IDLE   | memory free; arbitrate between A and B at each edge
  // ACCESS | strobes driven from latched request for LATENCY cycles
  // RESP   | one-cycle response (rvalid/rdata/err) to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int BW_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [BW_W-1:0]  BW_MAX    = BW_W'(STARVE_LIMIT);
  localparam logic [31:0]      LAST_WORD = 32'(ADDR_LIMIT - 4);

  state_t            state_q, state_d;
  logic              owner_b_q, owner_b_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [BW_W-1:0]   b_wait_q, b_wait_d;
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;

  logic              pick_a, pick_b;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              req_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      b_wait_q  <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_b_q <= owner_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      b_wait_q  <= b_wait_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_b_d = owner_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    b_wait_d  = b_wait_q;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;

    // B wins when A is absent or B has already waited out its quota
    pick_b    = b_req & (~a_req | (b_wait_q == BW_MAX));
    pick_a    = a_req & ~pick_b;
    req_we    = pick_b ? b_we    : a_we;
    req_addr  = pick_b ? b_addr  : a_addr;
    req_wdata = pick_b ? b_wdata : a_wdata;
    req_bad   = (req_addr[1:0] != 2'b00) | (req_addr > LAST_WORD);

    case (state_q)
      IDLE: begin
        if (pick_a | pick_b) begin
          owner_b_d = pick_b;
          we_d      = req_we;
          err_d     = req_bad;
          rdata_d   = '0;
          a_gnt_d   = pick_a;
          b_gnt_d   = pick_b;
          if (pick_b)
            b_wait_d = '0;
          else if (b_req && (b_wait_q != BW_MAX))
            b_wait_d = b_wait_q + BW_W'(1);
          if (req_bad) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = we_q ? 32'h0 : ReadData;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign MemRead   = (state_q == ACCESS) & ~we_q;
  assign MemWrite  = (state_q == ACCESS) &  we_q;
  assign Address   = addr_q;
  assign WriteData = wdata_q;

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = (state_q == RESP) & ~owner_b_q;
  assign b_rvalid = (state_q == RESP) &  owner_b_q;
  assign a_rdata  = a_rvalid ? rdata_q : 32'h0;
  assign b_rdata  = b_rvalid ? rdata_q : 32'h0;
  assign a_err    = a_rvalid & err_q;
  assign b_err    = b_rvalid & err_q;
  assign stall    = a_req & ~a_rvalid;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: single-access vector table, hand-written
// reset/starvation/contention sequences, and a randomized run against a timeline model.
module tb_dmem_access_arbiter;
  localparam int L     = 2;
  localparam int LIMIT = 208;
  localparam int SL    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata, ReadData;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata, Address, WriteData;
  logic        stall, MemRead, MemWrite;

  always #5 clk = ~clk;

  dmem_access_arbiter #(.LATENCY(L), .ADDR_LIMIT(LIMIT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .stall(stall), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    ReadData = 0;
  endtask

  // ends at a negedge with reset released
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    logic [31:0] rdata;
    int          reads;
    int          writes;
    int          resp;
  } vec_t;

  vec_t vecs[7];

  // one A access from an idle arbiter; A holds its request until its response
  task automatic run_a_txn(input vec_t v, input int idx);
    int gnt_cyc, resp_cyc, reads, writes;
    gnt_cyc = -1; resp_cyc = -1; reads = 0; writes = 0;
    @(posedge clk); #1;
    a_req = 1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; ReadData = v.rd;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_gnt && gnt_cyc < 0) gnt_cyc = c;
      if (MemRead)  reads++;
      if (MemWrite) writes++;
      if (MemRead || MemWrite) check($sformatf("v%0d Address", idx), Address, v.addr);
      if (MemWrite) check($sformatf("v%0d WriteData", idx), WriteData, v.wdata);
      check($sformatf("v%0d stall c%0d", idx, c), stall, a_req && (c < v.resp));
      if (a_rvalid) begin
        resp_cyc = c;
        check($sformatf("v%0d a_rdata", idx), a_rdata, v.rdata);
        check($sformatf("v%0d a_err", idx), a_err, v.err);
      end
      @(posedge clk); #1;
      if (resp_cyc >= 0) a_req = 0;
    end
    check($sformatf("v%0d gnt cycle", idx), gnt_cyc, 1);
    check($sformatf("v%0d resp cycle", idx), resp_cyc, v.resp);
    check($sformatf("v%0d read strobes", idx), reads, v.reads);
    check($sformatf("v%0d write strobes", idx), writes, v.writes);
  endtask

  // timeline reference model: each grant at edge k books gnt in cycle k,
  // strobes in cycles k..k+L-1 and the response in cycle k+L (or k on error)
  int          idle_from, m_g, m_r, m_bw;
  logic        m_own_b, m_err, m_we, granted_a, granted_b;
  logic [31:0] m_rdata, m_addr, m_wdata;

  task automatic model_reset();
    idle_from = 0; m_g = -100; m_r = -100; m_bw = 0;
    m_own_b = 0; m_err = 1; m_we = 0; m_rdata = 0; m_addr = 0; m_wdata = 0;
    granted_a = 0; granted_b = 0;
  endtask

  task automatic model_edge(input int k);
    logic win_a, win_b;
    logic [31:0] addr;
    granted_a = 0; granted_b = 0;
    if (!m_err && k == m_g + L) m_rdata = m_we ? 32'h0 : ReadData;
    if (k - 1 >= idle_from) begin
      win_b = b_req && (!a_req || m_bw == SL);
      win_a = !win_b && a_req;
      if (win_a || win_b) begin
        addr    = win_b ? b_addr : a_addr;
        m_own_b = win_b;
        m_we    = win_b ? b_we : a_we;
        m_err   = (addr % 4 != 0) || (addr > 32'(LIMIT - 4));
        m_rdata = 0;
        m_g     = k;
        m_r     = m_err ? k : k + L;
        idle_from = m_r + 1;
        if (!m_err) begin
          m_addr  = addr;
          m_wdata = win_b ? b_wdata : a_wdata;
        end
        if (win_b) m_bw = 0;
        else if (b_req) m_bw = (m_bw + 1 > SL) ? SL : m_bw + 1;
        granted_a = win_a; granted_b = win_b;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 51) * 4 + $urandom_range(1, 3));
      2:       return 32'(LIMIT - 4);
      3:       return 32'(LIMIT);
      default: return 32'($urandom_range(0, 51) * 4);
    endcase
  endfunction

  initial begin
    string order;
    int    gcyc[8];
    int    ng, ag, bg, arv, brv, a_rv_seen, k;
    logic  a_pend, b_pend;
    logic  e_acc, e_rv;

    vecs[0] = '{1'b0, 32'h10, 32'h0,        32'h04040404, 1'b0, 32'h04040404, 2, 0, L + 1};
    vecs[1] = '{1'b1, 32'h20, 32'hDEADBEEF, 32'h55AA55AA, 1'b0, 32'h0,        0, 2, L + 1};
    vecs[2] = '{1'b0, 32'h11, 32'h0,        32'h11111111, 1'b1, 32'h0,        0, 0, 1};
    vecs[3] = '{1'b0, 32'hD0, 32'h0,        32'h22222222, 1'b1, 32'h0,        0, 0, 1};
    vecs[4] = '{1'b0, 32'hCC, 32'h0,        32'h12345678, 1'b0, 32'h12345678, 2, 0, L + 1};
    vecs[5] = '{1'b1, 32'hCE, 32'hCAFEF00D, 32'h0,        1'b1, 32'h0,        0, 0, 1};
    vecs[6] = '{1'b1, 32'h0,  32'h0BADF00D, 32'h33333333, 1'b0, 32'h0,        0, 2, L + 1};

    reset = 1'b1;
    clear_inputs();
    #1;
    check("rst a_gnt", a_gnt, 0);       check("rst b_gnt", b_gnt, 0);
    check("rst a_rvalid", a_rvalid, 0); check("rst b_rvalid", b_rvalid, 0);
    check("rst MemRead", MemRead, 0);   check("rst MemWrite", MemWrite, 0);
    check("rst Address", Address, 0);   check("rst WriteData", WriteData, 0);
    check("rst a_err", a_err, 0);       check("rst stall", stall, 0);
    do_reset();

    foreach (vecs[i]) run_a_txn(vecs[i], i);

    // reset during the second ACCESS cycle, B waiting
    do_reset();
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 32'h40; b_req = 1; b_we = 0; b_addr = 32'h44;
    @(posedge clk); @(posedge clk); #2;
    check("pre-reset MemRead", MemRead, 1);
    reset = 1'b1; #1;
    check("mid-reset MemRead", MemRead, 0);   check("mid-reset a_gnt", a_gnt, 0);
    check("mid-reset a_rvalid", a_rvalid, 0); check("mid-reset b_gnt", b_gnt, 0);
    check("mid-reset Address", Address, 0);
    a_req = 0;
    @(negedge clk); reset = 1'b0;
    bg = -1; brv = -1; a_rv_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_rvalid || a_gnt) a_rv_seen++;
      if (b_gnt && bg < 0) begin bg = c; b_req = 0; end
      if (b_rvalid && brv < 0) brv = c;
    end
    check("post-reset stale A activity", a_rv_seen, 0);
    check("post-reset b_gnt cycle", bg, 0);
    check("post-reset b_rvalid cycle", brv, L);

    // starvation guard with both requesters held high
    do_reset();
    @(posedge clk); #1;
    a_req = 1; a_addr = 32'h0; b_req = 1; b_addr = 32'h4;
    order = ""; ng = 0;
    for (int c = 0; c < 8 * (L + 2) + 10 && ng < 8; c++) begin
      @(negedge clk);
      if (a_gnt) begin order = {order, "A"}; gcyc[ng] = c; ng++; end
      else if (b_gnt) begin order = {order, "B"}; gcyc[ng] = c; ng++; end
    end
    check("starve grant count", ng, 8);
    total++;
    if (order != "AAABAAAB") begin
      bad++;
      $display("FAIL starve order: got %s want AAABAAAB", order);
    end
    for (int i = 1; i < ng; i++) check($sformatf("starve spacing %0d", i), gcyc[i] - gcyc[i-1], L + 2);
    a_req = 0; b_req = 0;
    repeat (L + 3) @(posedge clk);

    // simultaneous first requests from a fresh reset
    do_reset();
    @(posedge clk); #1;
    a_req = 1; a_addr = 32'h8; b_req = 1; b_addr = 32'hC;
    ag = -1; bg = -1; arv = -1; brv = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_gnt && ag < 0) ag = c;
      if (b_gnt && bg < 0) bg = c;
      if (a_rvalid && arv < 0) begin arv = c; a_req = 0; end
      if (b_rvalid && brv < 0) begin brv = c; b_req = 0; end
    end
    check("simul a_gnt cycle", ag, 1);
    check("simul b_gnt cycle", bg, 1 + L + 2);
    check("simul rvalid gap", brv - arv, L + 2);

    // randomized traffic against the timeline model
    do_reset();
    model_reset();
    a_pend = 0; b_pend = 0;
    k = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      k++;
      model_edge(k);
      #1;
      if (granted_a) a_pend = 0;
      if (granted_b) b_pend = 0;
      if (a_pend) begin
        if ($urandom_range(0, 15) == 0) begin a_req = 0; a_pend = 0; end
      end else if ($urandom_range(0, 1) == 0) begin
        a_req = 1; a_pend = 1; a_we = 1'($urandom_range(0, 1));
        a_addr = rand_addr(); a_wdata = $urandom;
      end else a_req = 0;
      if (b_pend) begin
        if ($urandom_range(0, 15) == 0) begin b_req = 0; b_pend = 0; end
      end else if ($urandom_range(0, 1) == 0) begin
        b_req = 1; b_pend = 1; b_we = 1'($urandom_range(0, 1));
        b_addr = rand_addr(); b_wdata = $urandom;
      end else b_req = 0;
      ReadData = $urandom;
      @(negedge clk);
      e_acc = !m_err && k >= m_g && k < m_g + L;
      e_rv  = (k == m_r);
      check("rnd a_gnt", a_gnt, (k == m_g) && !m_own_b);
      check("rnd b_gnt", b_gnt, (k == m_g) &&  m_own_b);
      check("rnd MemRead", MemRead, e_acc && !m_we);
      check("rnd MemWrite", MemWrite, e_acc && m_we);
      check("rnd Address", Address, m_addr);
      check("rnd WriteData", WriteData, m_wdata);
      check("rnd a_rvalid", a_rvalid, e_rv && !m_own_b);
      check("rnd b_rvalid", b_rvalid, e_rv &&  m_own_b);
      check("rnd stall", stall, a_req && !(e_rv && !m_own_b));
      if (e_rv && !m_own_b) begin
        check("rnd a_rdata", a_rdata, m_rdata);
        check("rnd a_err", a_err, m_err);
      end
      if (e_rv && m_own_b) begin
        check("rnd b_rdata", b_rdata, m_rdata);
        check("rnd b_err", b_err, m_err);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Sequences and shares the single-ported data memory between two requesters.
  - Port A: pipeline MEM stage, high priority.
  - Port B: debug/loader port, low priority, with a starvation guard.
- Latches the winning request and drives the memory strobes for a fixed number of cycles. It then returns a one-cycle response and stalls the pipeline while port A is waiting.
- Sits between the MEM stage / debug port and the data memory; 32-bit byte addresses, word accesses only.

Parameters:
- LATENCY, 2, cycles the memory strobes are held per access (>=1).
- ADDR_LIMIT, 208, byte size of the memory; addresses >= ADDR_LIMIT are errors.
- STARVE_LIMIT, 3, consecutive A grants while B is requesting before B is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  A request; held until a_gnt.
- a_we  in  1  A write (1) / read (0).
- a_addr  in  32  A byte address.
- a_wdata  in  32  A write data.
- a_gnt  out  1  A request latched, one-cycle pulse.
- a_rvalid  out  1  A response, one-cycle pulse.
- a_rdata  out  32  A read data, valid with a_rvalid.
- a_err  out  1  A error flag, valid with a_rvalid.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err  same widths and meaning as A for port B.
- stall  out  1  pipeline stall = a_req & ~a_rvalid (combinational).
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- Address  out  32  memory byte address.
- WriteData  out  32  memory write data.
- ReadData  in  32  memory read data.

Behaviour:
- States: IDLE, ACCESS, RESP. Registers: state, owner (A/B), latched we/addr/wdata, cycle counter, rdata, err, b_wait counter.
- Reset (asynchronous, immediate):
  - state=IDLE.
  - All gnt/rvalid/err/MemRead/MemWrite = 0.
  - Address/WriteData/rdata = 0.
  - b_wait = 0.
  - An in-flight access is abandoned; no response is ever issued for it.
- IDLE arbitration at each edge:
  - If b_req and (~a_req or b_wait==STARVE_LIMIT): B wins. Otherwise, if a_req: A wins.
  - The winner's we/addr/wdata are latched and the winner's gnt pulses high for the next cycle.
- b_wait update at each grant:
  - A granted while b_req=1: b_wait+1, saturating at STARVE_LIMIT.
  - B granted: b_wait=0.
  - A granted while b_req=0: b_wait unchanged.
- Error check at grant:
  - An error is latched when addr[1:0]!=0, or addr>ADDR_LIMIT-4 (the word does not fit within ADDR_LIMIT).
  - On error: next state is RESP directly; MemRead/MemWrite never assert; err=1; rdata=0.
- Valid request: next state is ACCESS.
  - For LATENCY cycles, Address and WriteData come from the latched registers. MemRead=~we and MemWrite=we, exactly one high.
  - ReadData is captured on the final ACCESS edge; the state then moves to RESP.
- RESP lasts one cycle:
  - Owner's rvalid=1, rdata = captured value (0 for writes), err as latched.
  - Next state is always IDLE.
- Timing:
  - req high before edge 1 -> gnt high in cycle 1; strobes high in cycles 1..LATENCY.
  - rvalid high in cycle LATENCY+1.
  - Next grant no earlier than cycle LATENCY+3.
  - Throughput: one access per LATENCY+2 cycles.
- Outside ACCESS, strobes are 0 and Address/WriteData hold their last values.
- A requester must not change its fields between req assertion and gnt. After gnt it may drop req or present a new request; a new request is not sampled before the next IDLE.
- a_req and b_req in the same IDLE cycle with b_wait<STARVE_LIMIT: A wins.
- A request dropped before grant is simply not served; there is no error for it.

Test Plan:
- A read, addr=0x10, ReadData=0x04040404, LATENCY=2 -> a_gnt in cycle 1; MemRead in cycles 1-2; a_rvalid in cycle 3 with a_rdata=0x04040404 and a_err=0; stall high in cycles 0-2 only.
- A write, addr=0x20, wdata=0xDEADBEEF -> MemWrite high for 2 cycles with Address=0x20 and WriteData=0xDEADBEEF; MemRead stays 0; a_rvalid pulses with a_rdata=0.
- Error requests: A read at addr=0x11, then at addr=0xD0 -> each gives a_rvalid with a_err=1, and MemRead/MemWrite never assert. A read at 0xCC -> normal access.
- Starvation: a_req and b_req held high continuously -> grants in the order A,A,A,B,A,A,A,B; b_wait returns to 0 after each B grant.
- Reset mid-operation: assert reset during the second ACCESS cycle -> strobes, gnt and rvalid drop immediately and no response is issued. After release, a held b_req is granted from IDLE.
- Simultaneous first requests, b_wait=0 -> A is granted first; B is granted in the next IDLE; b_rvalid arrives LATENCY+2 cycles after a_rvalid.
